// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential MiniMIPS ALU (alu_seq) and its
// iterative multiply core (alu_mult_iter).
//   OP_*     : 3-bit operation select encodings
//   state_t  : FSM state encoding for alu_seq (ST_IDLE / ST_MUL / ST_DONE)
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam logic [2:0] OP_AND  = 3'b000;
   localparam logic [2:0] OP_ADD  = 3'b001;
   localparam logic [2:0] OP_SUB  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_NOR  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_SLT  = 3'b110;
   localparam logic [2:0] OP_MULT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_MUL  = 2'b01,
      ST_DONE = 2'b10
   } state_t;

endpackage

// File: rtl/alu_mult_iter.sv
// ---------------------------------------------------------------------------
// alu_mult_iter
// Unsigned shift-add multiplier, one partial-product step per clock.
// A start pulse loads the operands; WIDTH steps later done is high and prod
// holds a*b. done stays high until the next start.
// Ports:
//   clk    in   1          rising-edge clock
//   reset  in   1          synchronous, active-high reset
//   start  in   1          load a/b and restart the iteration
//   a      in   WIDTH      multiplicand (unsigned)
//   b      in   WIDTH      multiplier (unsigned)
//   done   out  1          WIDTH steps completed since the last start
//   prod   out  2*WIDTH    unsigned product
// ---------------------------------------------------------------------------
module alu_mult_iter #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 done,
   output logic [2*WIDTH-1:0]   prod
);

   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;   // multiplier bits shift out as product bits shift in
   logic [CNT_W-1:0] count;
   logic [WIDTH:0]   sum;      // WIDTH+1-bit accumulator keeps the carry of each step

   assign sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);

   // NOTE: sequential state is written with non-blocking assignments only, so
   // every register in the block samples the values from before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         count  <= '0;
      end else if (start) begin
         mcand  <= a;
         acc_hi <= '0;
         acc_lo <= b;
         count  <= '0;
      end else if (count != LAST) begin
         // Shift {sum, acc_lo} right by one: the new product bit enters acc_lo.
         acc_hi <= sum[WIDTH:1];
         acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
         count  <= count + CNT_W'(1);
      end
   end

   // Steps taken after reset without a start only shift zeros and are never observed.
   assign done = (count == LAST);
   assign prod = {acc_hi, acc_lo};

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Handshaked sequential MiniMIPS ALU. Logic/arithmetic ops complete one cycle
// after accept; MULT runs on alu_mult_iter and completes WIDTH+1 cycles after
// accept. Results are held until the consumer takes them.
// Optional feature macro: ALU_MULT_HI_EN adds result_hi (high half of the
// signed MULT product, 0 for other ops).
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-high reset
//   in_valid   in   1      operands/select valid
//   in_ready   out  1      op can be accepted this cycle
//   value1     in   WIDTH  operand A (signed)
//   value2     in   WIDTH  operand B (signed)
//   select     in   3      operation select (see alu_pkg OP_*)
//   out_valid  out  1      result valid, held until out_ready
//   out_ready  in   1      consumer accepts result
//   result     out  WIDTH  registered result
//   busy       out  1      multiply in progress
//   result_hi  out  WIDTH  (ALU_MULT_HI_EN only) high half of MULT product
// ---------------------------------------------------------------------------
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  value1,
   input  logic [WIDTH-1:0]  value2,
   input  logic [2:0]        select,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WIDTH-1:0]  result,
   output logic              busy
`ifdef ALU_MULT_HI_EN
   ,
   output logic [WIDTH-1:0]  result_hi
`endif
);

   import alu_pkg::*;

   state_t             state;
   logic               neg;          // product sign, latched at MULT accept
   logic               accept;
   logic               mul_start;
   logic               mul_done;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   alu_out;
   logic [WIDTH-1:0]   mul_lo;
   logic [WIDTH:0]     ext1, ext2, mag1, mag2;
   logic [1:0]         unused_mag_msb;

   assign in_ready  = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
   assign accept    = in_valid & in_ready;
   assign mul_start = accept & (select == OP_MULT);

   // Magnitudes are formed in WIDTH+1 bits so the most-negative operand has a
   // representable absolute value; its top bit is always 0 afterwards.
   assign ext1 = {value1[WIDTH-1], value1};
   assign ext2 = {value2[WIDTH-1], value2};
   assign mag1 = ext1[WIDTH] ? -ext1 : ext1;
   assign mag2 = ext2[WIDTH] ? -ext2 : ext2;
   assign unused_mag_msb = {mag1[WIDTH], mag2[WIDTH]};

   // NOTE: every output of a combinational block gets a default first, so no
   // select value can leave it unassigned and infer a latch.
   always_comb begin
      alu_out = '0;
      case (select)
         OP_AND:  alu_out = value1 & value2;
         OP_ADD:  alu_out = value1 + value2;
         OP_SUB:  alu_out = value1 - value2;
         OP_XOR:  alu_out = value1 ^ value2;
         OP_NOR:  alu_out = ~(value1 | value2);
         OP_OR:   alu_out = value1 | value2;
         OP_SLT:  alu_out = {{(WIDTH-1){1'b0}}, ($signed(value1) < $signed(value2))};
         default: alu_out = '0;   // MULT result comes from the iterative core
      endcase
   end

   alu_mult_iter #(.WIDTH(WIDTH)) u_mult (
      .clk   (clk),
      .reset (reset),
      .start (mul_start),
      .a     (mag1[WIDTH-1:0]),
      .b     (mag2[WIDTH-1:0]),
      .done  (mul_done),
      .prod  (prod)
   );

`ifdef ALU_MULT_HI_EN
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   mul_hi;
   assign prod_s = neg ? -prod : prod;
   assign mul_lo = prod_s[WIDTH-1:0];
   assign mul_hi = prod_s[2*WIDTH-1:WIDTH];
`else
   // Low half of a negated product equals the negated low half, so only the
   // low WIDTH bits are sign-corrected and the high half is dropped.
   logic [WIDTH-1:0] unused_prod_hi;
   assign mul_lo         = neg ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
   assign unused_prod_hi = prod[2*WIDTH-1:WIDTH];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         busy      <= 1'b0;
         neg       <= 1'b0;
`ifdef ALU_MULT_HI_EN
         result_hi <= '0;
`endif
      end else begin
         case (state)
            // DONE with out_ready behaves like IDLE, giving back-to-back issue.
            ST_IDLE, ST_DONE: begin
               if (accept) begin
                  if (select == OP_MULT) begin
                     state     <= ST_MUL;
                     busy      <= 1'b1;
                     out_valid <= 1'b0;
                     neg       <= value1[WIDTH-1] ^ value2[WIDTH-1];
                  end else begin
                     state     <= ST_DONE;
                     out_valid <= 1'b1;
                     result    <= alu_out;
`ifdef ALU_MULT_HI_EN
                     result_hi <= '0;
`endif
                  end
               end else if ((state == ST_DONE) && out_ready) begin
                  state     <= ST_IDLE;
                  out_valid <= 1'b0;
               end
            end
            ST_MUL: begin
               if (mul_done) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  out_valid <= 1'b1;
                  result    <= mul_lo;
`ifdef ALU_MULT_HI_EN
                  result_hi <= mul_hi;
`endif
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Self-checking bench for alu_seq (WIDTH=32). A scoreboard of expected
// results, computed with plain integer arithmetic, is compared against every
// presented result; directed sequences add literal expectations for latency,
// backpressure, reset abort and back-to-back streaming.
// ---------------------------------------------------------------------------
module tb_alu_seq;

   localparam int W = 32;
   localparam logic [2:0] T_AND = 3'd0, T_ADD = 3'd1, T_SUB = 3'd2, T_XOR = 3'd3,
                          T_NOR = 3'd4, T_OR  = 3'd5, T_SLT = 3'd6, T_MUL = 3'd7;

   logic          clk = 1'b0;
   logic          reset;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  value1;
   logic [W-1:0]  value2;
   logic [2:0]    select;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  result;
   logic          busy;
`ifdef ALU_MULT_HI_EN
   logic [W-1:0]  result_hi;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int n_pop = 0;

   typedef struct packed {
      logic [W-1:0] lo;
      logic [W-1:0] hi;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .value1    (value1),
      .value2    (value2),
      .select    (select),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
`ifdef ALU_MULT_HI_EN
      ,
      .result_hi (result_hi)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference behaviour from the op definitions, using 64-bit integers.
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t        e;
      longint      sa, sb, p;
      logic [63:0] pv;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = sa * sb;
      pv = p;
      e.hi = '0;
      case (op)
         T_AND:   e.lo = a & b;
         T_ADD:   e.lo = a + b;
         T_SUB:   e.lo = a - b;
         T_XOR:   e.lo = a ^ b;
         T_NOR:   e.lo = ~(a | b);
         T_OR:    e.lo = a | b;
         T_SLT:   e.lo = (sa < sb) ? 32'd1 : 32'd0;
         default: begin
            e.lo = pv[31:0];
            e.hi = pv[63:32];
         end
      endcase
      return e;
   endfunction

   // Compare process: every presented result against the scoreboard head.
   always @(negedge clk) begin
      if (reset) begin
         sb_q.delete();
      end else begin
         if (sb_q.size() == 0) begin
            check("out_valid_when_nothing_pending", {63'd0, out_valid}, 64'd0);
            check("in_ready_when_idle", {63'd0, in_ready}, 64'd1);
         end else if (out_valid) begin
            check("result_vs_model", {32'd0, result}, {32'd0, sb_q[0].lo});
`ifdef ALU_MULT_HI_EN
            check("result_hi_vs_model", {32'd0, result_hi}, {32'd0, sb_q[0].hi});
`endif
            check("in_ready_while_presenting", {63'd0, in_ready}, {63'd0, out_ready});
            if (out_ready) begin
               void'(sb_q.pop_front());
               n_pop++;
            end
         end
         if (in_valid && in_ready)
            sb_q.push_back(model(select, value1, value2));
      end
   end

   // Drive point: just after a rising edge.
   task automatic to_drive();
      @(posedge clk);
      #1;
   endtask

   // Present an op and hold it until accepted; waits = stalled cycles.
   // Call at a drive point; returns at the drive point after the accept edge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int waits);
      bit done;
      select   = op;
      value1   = a;
      value2   = b;
      in_valid = 1'b1;
      waits    = 0;
      done     = 0;
      while (!done) begin
         #1;
         if (in_ready) begin
            @(posedge clk);
            #1;
            done = 1;
         end else begin
            waits++;
            if (waits > 200) begin
               n_cmp++;
               n_bad++;
               $display("FAIL issue_timeout: op %0d not accepted after %0d cycles", op, waits);
               done = 1;
            end else begin
               @(posedge clk);
            end
         end
      end
   endtask

   task automatic mult_check(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
      int w, lat, gaps;
      issue(T_MUL, a, b, w);
      in_valid = 1'b0;
      lat  = -1;
      gaps = 0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = i - 1;   // edges elapsed since the accept edge
            break;
         end
         if (!busy) gaps++;
      end
      check("mult_latency", lat, 33);
      check("mult_busy_throughout", gaps, 0);
      check("mult_busy_cleared", {63'd0, busy}, 64'd0);
      check("mult_result", {32'd0, result}, {32'd0, exp_lo});
`ifdef ALU_MULT_HI_EN
      check("mult_result_hi", {32'd0, result_hi}, {32'd0, exp_hi});
`else
      check("mult_model_hi", {32'd0, model(T_MUL, a, b).hi}, {32'd0, exp_hi});
`endif
      to_drive();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] exp1 [7];
      logic [2:0]   s6_op [8];
      logic [W-1:0] s6_a  [8];
      logic [W-1:0] s6_b  [8];
      int           w, pop0;
      exp_t         e;

      exp1 = '{32'h21, 32'h5C, 32'h0A, 32'h1A, 32'hFFFF_FFC4, 32'h3B, 32'h0};
      s6_op = '{T_ADD, T_SUB, T_AND, T_OR, T_XOR, T_NOR, T_SLT, T_SLT};
      s6_a  = '{32'h1, 32'h0, 32'hFFFF_0000, 32'h1234_0000, 32'hDEAD_BEEF,
                32'h0F0F_0F0F, 32'h7FFF_FFFF, 32'hFFFF_FFFF};
      s6_b  = '{32'hFFFF_FFFF, 32'h1, 32'h00FF_FF00, 32'h0000_5678, 32'hFFFF_FFFF,
                32'h00F0_00F0, 32'h8000_0000, 32'h0000_0000};

      reset     = 1'b1;
      in_valid  = 1'b0;
      value1    = '0;
      value2    = '0;
      select    = '0;
      out_ready = 1'b1;

      // Pin the model on hand-computed values.
      e = model(T_MUL, 32'hFFFF_FFFD, 32'd5);
      check("model_mult_lo", {32'd0, e.lo}, 64'hFFFF_FFF1);
      check("model_mult_hi", {32'd0, e.hi}, 64'hFFFF_FFFF);
      e = model(T_SLT, 32'hAAAA_AAAA, 32'h3333_3333);
      check("model_slt", {32'd0, e.lo}, 64'd1);

      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_out_valid", {63'd0, out_valid}, 64'd0);
      check("reset_result", {32'd0, result}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_in_ready", {63'd0, in_ready}, 64'd1);
      to_drive();

      // Ops 000..110 on 0x33 / 0x29, each with one-cycle latency.
      for (int i = 0; i < 7; i++) begin
         issue(3'(i), 32'h33, 32'h29, w);
         in_valid = 1'b0;
         @(negedge clk);
         check("t1_out_valid", {63'd0, out_valid}, 64'd1);
         check("t1_result", {32'd0, result}, {32'd0, exp1[i]});
         to_drive();
      end

      // Signed compare and wrapping arithmetic.
      issue(T_SLT, 32'hAAAA_AAAA, 32'h3333_3333, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("t2_slt", {32'd0, result}, 64'd1);
      to_drive();
      issue(T_ADD, 32'hAAAA_AAAA, 32'h3333_3333, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("t2_add", {32'd0, result}, 64'hDDDD_DDDD);
      to_drive();
      issue(T_SUB, 32'hAAAA_AAAA, 32'h3333_3333, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("t2_sub", {32'd0, result}, 64'h7777_7777);
      to_drive();

      // Multiplies, including the most-negative operand.
      mult_check(32'h33, 32'h29, 32'h0000_082B, 32'h0);
      mult_check(32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, 32'hFFFF_FFFF);
      mult_check(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
      mult_check(32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000);

      // Backpressure, then same-cycle handoff to a new op.
      out_ready = 1'b0;
      issue(T_ADD, 32'h100, 32'h23, w);
      in_valid = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("t4_hold_valid", {63'd0, out_valid}, 64'd1);
         check("t4_hold_result", {32'd0, result}, 64'h123);
         check("t4_hold_in_ready", {63'd0, in_ready}, 64'd0);
      end
      to_drive();
      out_ready = 1'b1;
      issue(T_XOR, 32'hF0F0, 32'h00FF, w);
      in_valid = 1'b0;
      check("t4_same_cycle_accept", w, 0);
      @(negedge clk);
      check("t4_xor_valid", {63'd0, out_valid}, 64'd1);
      check("t4_xor_result", {32'd0, result}, 64'hF00F);
      to_drive();

      // Reset in the middle of a multiply discards it.
      issue(T_MUL, 32'd7, 32'd9, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("t5_busy_before_reset", {63'd0, busy}, 64'd1);
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("t5_out_valid", {63'd0, out_valid}, 64'd0);
      check("t5_result", {32'd0, result}, 64'd0);
      check("t5_busy", {63'd0, busy}, 64'd0);
      check("t5_in_ready", {63'd0, in_ready}, 64'd1);
      to_drive();
      issue(T_AND, 32'hFF00, 32'h0FF0, w);
      in_valid = 1'b0;
      @(negedge clk);
      check("t5_and_after_reset", {32'd0, result}, 64'h0F00);
      to_drive();

      // Back-to-back stream of eight non-MULT ops.
      pop0 = n_pop;
      for (int i = 0; i < 8; i++) begin
         issue(s6_op[i], s6_a[i], s6_b[i], w);
         check("t6_no_stall", w, 0);
      end
      in_valid = 1'b0;
      check("t6_last_result_pending", {63'd0, out_valid}, 64'd1);
      check("t6_last_slt", {32'd0, result}, 64'd1);
      repeat (3) @(negedge clk);
      check("t6_results_delivered", n_pop - pop0, 8);
      check("scoreboard_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
